// File: rtl/uart_rx_stage.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM and a one-byte holding register.
// Define UART_RX_FIFO_EN to replace the holding register with a FIFO_DEPTH-entry circular FIFO.
module uart_rx_stage #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       uart_rx_pin,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_error,
  output logic       overrun,
  output logic       rx_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

  logic [1:0]       sync_reg;
  logic [1:0]       fill_reg;
  logic             armed_reg;
  logic             line;
  logic [2:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       bit_cnt_reg;
  logic [7:0]       shift_reg;
  logic             frame_error_reg;
  logic             overrun_reg;
  logic             bit_done;
  logic             stop_sample;
  logic             push;

  assign line        = sync_reg[1];
  assign bit_done    = (cnt_reg == BIT_LAST);
  assign stop_sample = (state_reg == ST_STOP) && bit_done;
  assign push        = stop_sample && line;

  assign rx_busy     = (state_reg != ST_IDLE);
  assign frame_error = frame_error_reg;
  assign overrun     = overrun_reg;

  // The synchronizer resets to 1, so arming waits until real pin samples reach its output
  // and show an idle line; a line already low when reset releases cannot start a frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg  <= 2'b11;
      fill_reg  <= 2'b00;
      armed_reg <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[0], uart_rx_pin};
      fill_reg  <= {fill_reg[0], 1'b1};
      armed_reg <= armed_reg | (fill_reg[1] & line);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= ST_IDLE;
      cnt_reg         <= '0;
      bit_cnt_reg     <= 3'd0;
      shift_reg       <= 8'h00;
      frame_error_reg <= 1'b0;
    end else begin
      frame_error_reg <= stop_sample && !line;
      case (state_reg)
        ST_IDLE: begin
          cnt_reg <= '0;
          if (armed_reg && !line) state_reg <= ST_START;
        end
        ST_START: begin
          if (cnt_reg == HALF_LAST) begin
            cnt_reg     <= '0;
            bit_cnt_reg <= 3'd0;
            state_reg   <= line ? ST_IDLE : ST_DATA;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            cnt_reg     <= '0;
            shift_reg   <= {line, shift_reg[7:1]};
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) state_reg <= ST_STOP;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (bit_done) begin
            cnt_reg   <= '0;
            state_reg <= line ? ST_IDLE : ST_WAIT_IDLE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        ST_WAIT_IDLE: begin
          if (line) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

`ifdef UART_RX_FIFO_EN
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [7:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             pop;
  logic             full;
  logic             wr_en;

  assign pop   = (count_reg != '0) && rx_ready;
  assign full  = (count_reg == (PTR_W + 1)'(FIFO_DEPTH));
  // A pop in the same cycle frees the slot the new byte needs.
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr_reg] <= shift_reg;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      overrun_reg <= 1'b0;
    end else begin
      overrun_reg <= push && !wr_en;
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)   rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_reg + {{PTR_W{1'b0}}, wr_en} - {{PTR_W{1'b0}}, pop};
    end
  end

  assign rx_valid = (count_reg != '0);
  assign rx_data  = rx_valid ? mem[rd_ptr_reg] : 8'h00;
`else
  logic [7:0] hold_data_reg;
  logic       hold_valid_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_data_reg  <= 8'h00;
      hold_valid_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      overrun_reg <= 1'b0;
      if (push) begin
        if (hold_valid_reg && !rx_ready) begin
          overrun_reg <= 1'b1;
        end else begin
          hold_data_reg  <= shift_reg;
          hold_valid_reg <= 1'b1;
        end
      end else if (hold_valid_reg && rx_ready) begin
        hold_valid_reg <= 1'b0;
      end
    end
  end

  assign rx_valid = hold_valid_reg;
  assign rx_data  = hold_data_reg;
`endif

endmodule

// File: tb/tb_uart_rx_stage.sv
// Bench for uart_rx_stage at CLKS_PER_BIT=16: frame-level stimulus against a queue-based
// model of delivered bytes, frame errors and overruns (buffer capacity depends on UART_RX_FIFO_EN).
module tb_uart_rx_stage;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;
`ifdef UART_RX_FIFO_EN
  localparam int CAP = DEPTH;
`else
  localparam int CAP = 1;
`endif

  logic       clock = 1'b0;
  logic       reset_n;
  logic       uart_rx_pin;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_error;
  logic       overrun;
  logic       rx_busy;

  uart_rx_stage #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .uart_rx_pin (uart_rx_pin),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_error (frame_error),
    .overrun     (overrun),
    .rx_busy     (rx_busy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clock) cyc++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observations collected on the falling edge, where inputs and outputs are both settled.
  logic [7:0] got_q[$];
  int         fe_cnt = 0, ov_cnt = 0, valid_hi = 0, last_rise = -1;
  logic       prev_valid = 1'b0, prev_ready = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clock) begin
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    if (frame_error) fe_cnt++;
    if (overrun) ov_cnt++;
    if (rx_valid) valid_hi++;
    if (rx_valid && !prev_valid) last_rise = cyc;
    if (prev_valid && !prev_ready && reset_n)
      check_eq("hold_stable", {23'd0, rx_valid, rx_data}, {23'd0, 1'b1, prev_data});
    prev_valid = rx_valid;
    prev_ready = rx_ready;
    prev_data  = rx_data;
  end

  // Reference model: bytes the consumer should see, in order, plus event counts.
  logic [7:0] exp_q[$];
  logic [7:0] model_buf[$];
  int         exp_fe = 0, exp_ov = 0;

  function automatic void model_rx(input logic [7:0] b, input logic stop, input logic ready);
    if (!stop) exp_fe++;
    else if (ready) exp_q.push_back(b);
    else if (model_buf.size() < CAP) model_buf.push_back(b);
    else exp_ov++;
  endfunction

  function automatic void model_drain();
    while (model_buf.size() > 0) exp_q.push_back(model_buf.pop_front());
  endfunction

  task automatic clear_scoreboard();
    got_q.delete(); exp_q.delete(); model_buf.delete();
    fe_cnt = 0; ov_cnt = 0; exp_fe = 0; exp_ov = 0; valid_hi = 0; last_rise = -1;
  endtask

  task automatic compare_results(input string tag);
    check_eq({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_eq($sformatf("%s_byte%0d", tag, i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
    check_eq({tag, "_frame_err"}, fe_cnt, exp_fe);
    check_eq({tag, "_overrun"}, ov_cnt, exp_ov);
    clear_scoreboard();
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int start_cyc);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    @(posedge clock);
    #2;
    start_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      uart_rx_pin = bits[i];
      repeat (CPB) @(posedge clock);
      #2;
    end
  endtask

  initial begin
    int         sc;
    int         k;
    logic [7:0] b;
    logic       stop;

    reset_n = 1'b0; uart_rx_pin = 1'b1; rx_ready = 1'b0;
    tick(3);
    check_eq("reset_outputs", {20'd0, rx_data, rx_valid, frame_error, overrun, rx_busy}, 32'd0);
    reset_n = 1'b1;
    tick(5);
    clear_scoreboard();

    // Single clean frame with the consumer ready.
    rx_ready = 1'b1;
    send_frame(8'hA5, 1'b1, sc);
    model_rx(8'hA5, 1'b1, 1'b1);
    tick(20);
    check_eq("t1_latency", last_rise - sc, 155);
    check_eq("t1_valid_cycles", valid_hi, 1);
    compare_results("t1");

    // Bad stop bit followed by a long break, then a clean byte.
    send_frame(8'h3C, 1'b0, sc);
    model_rx(8'h3C, 1'b0, 1'b1);
    tick(50 * CPB);
    check_eq("t2_wait_busy", rx_busy, 1);
    check_eq("t2_no_repeat_err", fe_cnt, 1);
    uart_rx_pin = 1'b1;
    tick(10);
    check_eq("t2_idle_again", rx_busy, 0);
    send_frame(8'h55, 1'b1, sc);
    model_rx(8'h55, 1'b1, 1'b1);
    tick(20);
    check_eq("t2_valid_cycles", valid_hi, 1);
    compare_results("t2");

    // Short low glitch on an idle line.
    uart_rx_pin = 1'b0;
    tick(4);
    uart_rx_pin = 1'b1;
    tick(30);
    check_eq("t3_idle", rx_busy, 0);
    check_eq("t3_no_valid", valid_hi, 0);
    compare_results("t3");

    // One byte more than the buffer holds, consumer stalled.
    rx_ready = 1'b0;
    for (int i = 0; i <= CAP; i++) begin
      b = (CAP == 1) ? ((i == 0) ? 8'h11 : 8'h22) : 8'(i + 1);
      send_frame(b, 1'b1, sc);
      model_rx(b, 1'b1, 1'b0);
    end
    tick(20);
    check_eq("t4_head_held", rx_data, (CAP == 1) ? 32'h11 : 32'h01);
    check_eq("t4_overrun_once", ov_cnt, 1);
    rx_ready = 1'b1;
    model_drain();
    tick(10);
    compare_results("t4");

    // Full buffer: pop coincides with the push of a new byte.
    rx_ready = 1'b0;
    for (int i = 0; i < CAP; i++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1, sc);
      model_rx(b, 1'b1, 1'b0);
    end
    b = 8'($urandom_range(0, 255));
    fork
      send_frame(b, 1'b1, sc);
      begin
        @(posedge clock);
        repeat (154) @(posedge clock);
        #2 rx_ready = 1'b1;
        @(posedge clock);
        #2 rx_ready = 1'b0;
      end
    join
    exp_q.push_back(model_buf.pop_front());
    model_buf.push_back(b);
    tick(20);
    check_eq("t5_no_overrun", ov_cnt, 0);
    check_eq("t5_still_valid", rx_valid, 1);
    b = 8'($urandom_range(0, 255));
    send_frame(b, 1'b1, sc);
    model_rx(b, 1'b1, 1'b0);
    tick(20);
    rx_ready = 1'b1;
    model_drain();
    tick(10);
    compare_results("t5");

    // Random bytes with occasional bad stop bits and random idle gaps.
    rx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      send_frame(b, stop, sc);
      model_rx(b, stop, 1'b1);
      uart_rx_pin = 1'b1;
      tick($urandom_range(0, 20));
    end
    tick(20);
    compare_results("t6");

    // Random burst into a stalled consumer, then drain.
    rx_ready = 1'b0;
    k = $urandom_range(1, CAP + 2);
    for (int i = 0; i < k; i++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1, sc);
      model_rx(b, 1'b1, 1'b0);
    end
    tick(20);
    rx_ready = 1'b1;
    model_drain();
    tick(10);
    compare_results("t7");

    // Reset during data bit 3; the tail of the frame must not start a new one.
    fork
      send_frame(8'hF0, 1'b1, sc);
      begin
        @(posedge clock);
        repeat (66) @(posedge clock);
        #2 reset_n = 1'b0;
        @(negedge clock);
        check_eq("t8_reset_outputs", {20'd0, rx_data, rx_valid, frame_error, overrun, rx_busy}, 32'd0);
        repeat (3) @(posedge clock);
        #2 reset_n = 1'b1;
        repeat (7) @(posedge clock);
        #2;
        check_eq("t8_no_restart", rx_busy, 0);
      end
    join
    tick(20);
    send_frame(8'h7E, 1'b1, sc);
    model_rx(8'h7E, 1'b1, 1'b1);
    tick(20);
    compare_results("t8");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_stage.md
UART_RX_STAGE -- requirements
Module: uart_rx_stage

Interface
REQ-001 Parameter CLKS_PER_BIT, default 217, sets clock cycles per UART bit (25 MHz / 115200); legal range 8..65535.
REQ-002 Parameter FIFO_DEPTH, default 16, sets receive FIFO entries (power of 2, 2..256); it is used only when UART_RX_FIFO_EN is defined.
REQ-003 Port clock, input, 1 bit: single system clock (clk_25M domain); all logic is rising-edge.
REQ-004 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port uart_rx_pin, input, 1 bit: raw serial line, asynchronous to clock, idle high.
REQ-006 Port rx_data, output, 8 bits: received byte at the head of the buffer.
REQ-007 Port rx_valid, output, 1 bit: rx_data holds an unconsumed byte.
REQ-008 Port rx_ready, input, 1 bit: the consumer (uart_controller) accepts rx_data.
REQ-009 Port frame_error, output, 1 bit: one-cycle pulse when the stop bit is sampled low.
REQ-010 Port overrun, output, 1 bit: one-cycle pulse when a completed byte is dropped because the buffer is full.
REQ-011 Port rx_busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-012 uart_rx_pin passes through a 2-flop synchronizer; every use of "line" below means the synchronizer output.
REQ-013 FSM states are IDLE, START, DATA, STOP and WAIT_IDLE; a bit counter (0..7) and a cycle counter (width ceil(log2(CLKS_PER_BIT))) support it.
REQ-014 IDLE: when line is 0 at cycle t, the FSM goes to START and clears the cycle counter.
REQ-015 START: at t+CLKS_PER_BIT/2 (integer divide), line is resampled.
- If line is 0, the FSM goes to DATA.
- If line is 1 (glitch), the FSM returns to IDLE with no output and no error.
REQ-016 DATA: bit i (i=0..7, LSB first) is sampled at t+CLKS_PER_BIT/2+(i+1)*CLKS_PER_BIT into a shift register; after bit 7 the FSM goes to STOP.
REQ-017 STOP: the stop bit is sampled at t+CLKS_PER_BIT/2+9*CLKS_PER_BIT.
- If line is 1, the byte is pushed to the buffer and the FSM goes to IDLE.
- If line is 0, frame_error pulses on the next cycle, the byte is discarded, and the FSM goes to WAIT_IDLE.
REQ-018 WAIT_IDLE: the FSM stays until line is 1, then goes to IDLE (break conditions produce no repeated errors).
REQ-019 A pushed byte makes rx_valid high on the cycle after the stop sample; rx_data is stable while rx_valid=1 and rx_ready=0.
REQ-020 A byte is consumed on any cycle where rx_valid=1 and rx_ready=1; rx_ready while rx_valid=0 is ignored.
REQ-021 A push into a full buffer pulses overrun on the next cycle and drops the new byte; stored data is unchanged.
REQ-022 A push and a pop in the same cycle on a full buffer is not an overrun: the pop takes effect and the new byte is stored.
REQ-023 frame_error and overrun are never asserted for the same byte.

Reset
REQ-024 While reset_n=0, the following values hold:
- FSM is IDLE.
- All counters are 0.
- Synchronizer flops are 1.
- rx_data=0, rx_valid=0, frame_error=0, overrun=0, rx_busy=0.
- FIFO pointers and count are 0.
REQ-025 Reset asserted mid-frame abandons the frame.
REQ-026 After reset_n deasserts, reception starts only on a new high-to-low line transition, i.e. after line has been seen as 1 at least once.

Configuration
REQ-027 Macro UART_RX_FIFO_EN selects the buffer.
- Defined: the buffer is a FIFO_DEPTH-entry circular FIFO with wrapping read/write pointers and an occupancy counter. rx_valid = (count != 0). "Full" means count = FIFO_DEPTH.
- Undefined: the buffer is a single holding register. "Full" means rx_valid=1. FIFO_DEPTH is ignored.
- FSM timing and all other ports are identical in both builds.

Verification
REQ-028 Bench runs with CLKS_PER_BIT=16.
- Send 0xA5 with 8N1 framing, rx_ready=1 -> rx_valid pulses one cycle with rx_data=0xA5, 2+8+144+1 cycles after the start edge; no frame_error or overrun.
- Send 0x3C with the stop bit driven low -> frame_error pulses once, rx_valid stays 0; with the line held low for a further 50 bits, no further error; after the line returns high, 0x55 is received correctly.
- Apply a 4-cycle low glitch on an idle line -> FSM returns to IDLE; no rx_valid, no frame_error.
- Without FIFO, rx_ready=0, send 0x11 then 0x22 -> rx_data=0x11 is held and overrun pulses once. With UART_RX_FIFO_EN and FIFO_DEPTH=4, send 5 bytes 0x01..0x05 -> overrun on byte 5, then drain returns 0x01..0x04 in order.
- With the FIFO full, assert rx_ready in the same cycle as the push -> no overrun and count remains 4.
- Assert reset_n=0 during bit 3 of a frame -> all outputs return to 0; the remainder of the interrupted frame yields no spurious byte; the next full frame, 0x7E, is received correctly.
